// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Serializes word requests from the instruction cache (read-only) and the data
// cache (read/write) onto a single RAM port. Contested grants alternate between
// the two requesters. A per-access watchdog aborts an access if the RAM does
// not answer within TIMEOUT cycles.
//
// Handshake contract (both requesters):
//   A requester raises its enable (iREN, or dREN/dWEN) together with address
//   and write data, and holds the enable until it sees its wait line low.
//   iwait/dwait go low for exactly one cycle, the completion cycle, and the
//   matching iload/dload is valid only in that cycle. Address and data are
//   captured at grant; later changes are ignored until the next grant. If a
//   requester drops its enable mid-access, a normal RAM completion is
//   discarded (wait stays high). On the RAM side, ram_ren/ram_wen stay high
//   for the whole access, and ram_ready is a one-cycle pulse that ends it.
//
// Parameters:
//   TIMEOUT  cycles an access may wait for ram_ready before abort (2..255)
//   BAD      word returned on an aborted access
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   iREN, iaddr       icache read request and word address
//   iload, iwait      icache return word and completion handshake
//   dREN, dWEN        dcache read / write requests (both high = write)
//   daddr, dstore     dcache word address and write data
//   dload, dwait      dcache return word and completion handshake
//   ram_ren, ram_wen  RAM read / write strobes
//   ram_addr          RAM address (latched at grant)
//   ram_store         RAM write data (latched at data grant)
//   ram_load          RAM read data, valid with ram_ready
//   ram_ready         RAM completion pulse
//   bus_err           sticky watchdog-abort flag, cleared only by reset
//   dbg_state_o       current FSM state (0 idle, 1 instr, 2 data)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] BAD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        bus_err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INSTR = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  // Watchdog fires when the counter reaches this value without ram_ready.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_d_q;   // 1: most recent grant went to the data side
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        write_q;
  logic [7:0]  cnt_q;
  logic        bus_err_q;

  logic d_pend;
  logic grant_d;
  logic grant_i;
  logic busy;
  logic abort;

  // ---------------------------------------------------------------------------
  // Arbitration and watchdog decode
  // ---------------------------------------------------------------------------
  assign d_pend  = dREN | dWEN;
  // Data wins when it is alone, or when both pend and instr won last time.
  assign grant_d = d_pend & (~iREN | ~last_d_q);
  assign grant_i = iREN & ~grant_d;
  assign busy    = (state_q != S_IDLE);
  // A ready in the timeout cycle is a normal completion, not an abort.
  assign abort   = busy & (cnt_q == TO_LAST) & ~ram_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d = S_DATA;
        end else if (grant_i) begin
          state_d = S_INSTR;
        end
      end
      S_INSTR, S_DATA: begin
        if (ram_ready || abort) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Strobes are decoded from the state register so an asynchronous reset
  // drops them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_ren = 1'b0;
    ram_wen = 1'b0;
    iwait   = 1'b1;
    dwait   = 1'b1;
    iload   = ram_load;
    dload   = ram_load;
    case (state_q)
      S_INSTR: begin
        ram_ren = 1'b1;
        if (abort) begin
          iwait = 1'b0;
          iload = BAD;
        end else if (ram_ready && iREN) begin
          iwait = 1'b0;
        end
      end
      S_DATA: begin
        ram_ren = ~write_q;
        ram_wen = write_q;
        if (abort) begin
          dwait = 1'b0;
          dload = BAD;
        end else if (ram_ready && d_pend) begin
          dwait = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, fairness bit, watchdog counter, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_d_q  <= 1'b0;
      addr_q    <= 32'h0;
      store_q   <= 32'h0;
      write_q   <= 1'b0;
      cnt_q     <= 8'h0;
      bus_err_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      // ram_ready seen here is stray and deliberately ignored.
      if (grant_d) begin
        addr_q   <= daddr;
        store_q  <= dstore;
        write_q  <= dWEN;
        last_d_q <= 1'b1;
        cnt_q    <= 8'h0;
      end else if (grant_i) begin
        addr_q   <= iaddr;
        write_q  <= 1'b0;
        last_d_q <= 1'b0;
        cnt_q    <= 8'h0;
      end
    end else begin
      cnt_q <= cnt_q + 8'd1;
      if (abort) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign ram_addr    = addr_q;
  assign ram_store   = store_q;
  assign bus_err     = bus_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int          TIMEOUT = 4;
  localparam logic [31:0] BAD     = 32'hBAD1BAD1;
  localparam int          NEVER   = 255;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        bus_err;
  logic [1:0]  dbg_state_o;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  mem_arbiter #(.TIMEOUT(TIMEOUT), .BAD(BAD)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .bus_err(bus_err), .dbg_state_o(dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // exp_q entry: {port (1 = data), check_data, data}
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    int          lat;     // ram_ready in strobe cycle lat (0-based); >= TIMEOUT never
    logic [31:0] addr;
    logic        wr;
    logic [31:0] store;
    logic        abort;   // access is cut short by reset
  } acc_t;
  acc_t lat_q[$];

  logic [31:0] ram_mem [logic [31:0]];  // contents seen through the DUT
  logic [31:0] ref_mem [logic [31:0]];  // model's view of memory
  bit          model_last_d;
  bit          model_err;
  logic [31:0] model_last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Model one granted access, in the order the model says it is granted.
  task automatic plan(input bit is_d, input bit wr, input logic [31:0] a,
                      input logic [31:0] st, input int lat, input bit expect_done);
    acc_t e;
    e.lat = lat; e.addr = a; e.wr = wr; e.store = st; e.abort = 1'b0;
    lat_q.push_back(e);
    model_last_d    = is_d;
    model_last_addr = a;
    if (lat >= TIMEOUT) begin
      model_err = 1'b1;
      exp_q.push_back({is_d, 1'b1, BAD});
    end else if (wr) begin
      ref_mem[a] = st;
      exp_q.push_back({is_d, 1'b0, 32'h0});
    end else if (expect_done) begin
      exp_q.push_back({is_d, 1'b1, ref_read(a)});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops and compares whenever a wait line goes low
  // ---------------------------------------------------------------------------
  task automatic mon_pop(input bit port, input logic [31:0] val);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_completion: got port %0d expected none", port);
    end else begin
      e = exp_q.pop_front();
      check("completion_port", {31'b0, port}, {31'b0, e[33]});
      if (e[32]) check("load_data", val, e[31:0]);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (!iwait) mon_pop(1'b0, iload);
        if (!dwait) mon_pop(1'b1, dload);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM responder: answers each access after its planned latency and checks
  // the address, direction, write data and strobe length it sees.
  // ---------------------------------------------------------------------------
  initial begin
    acc_t cur;
    int   cnt;
    bit   active;
    active    = 1'b0;
    cnt       = 0;
    cur.lat = 0; cur.addr = 0; cur.wr = 0; cur.store = 0; cur.abort = 1'b1;
    ram_ready = 1'b0;
    ram_load  = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      ram_ready = 1'b0;
      ram_load  = $urandom;
      if (active && !(ram_ren || ram_wen)) begin
        active = 1'b0;
        if (!cur.abort)
          check("strobe_cycles", 32'(cnt), 32'((cur.lat >= TIMEOUT) ? TIMEOUT : cur.lat + 1));
      end
      if (!active && (ram_ren || ram_wen)) begin
        if (lat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unplanned_access: got addr %h expected none", ram_addr);
          cur.lat = NEVER; cur.addr = ram_addr; cur.wr = ram_wen; cur.store = 0; cur.abort = 1'b1;
        end else begin
          cur = lat_q.pop_front();
          check("ram_addr", ram_addr, cur.addr);
          check("ram_wen", 32'(ram_wen), 32'(cur.wr));
          check("ram_ren", 32'(ram_ren), 32'(!cur.wr));
          if (cur.wr) check("ram_store", ram_store, cur.store);
        end
        active = 1'b1;
        cnt    = 0;
      end
      if (active) begin
        if (cnt == cur.lat) begin
          ram_ready = 1'b1;
          if (ram_wen) ram_mem[ram_addr] = ram_store;
          else         ram_load = ram_read(ram_addr);
        end
        cnt++;
      end else if ($urandom_range(0, 3) == 0) begin
        ram_ready = 1'b1;  // stray pulse while idle
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Requesters hold their enable until they see wait low, then drop it.
  task automatic wait_idle();
    int n;
    bit di, dd;
    n = 0;
    while ((iREN || dREN || dWEN) && n < 200) begin
      @(negedge CLK);
      di = !iwait;
      dd = !dwait;
      @(posedge CLK);
      #1;
      if (di) iREN = 1'b0;
      if (dd) begin dREN = 1'b0; dWEN = 1'b0; end
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL completion_bound: got no completion in %0d cycles expected completion", n);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      exp_q.delete();
      lat_q.delete();
    end
    repeat (2) @(posedge CLK);
    #2;
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("lat_q_drained", 32'(lat_q.size()), 32'h0);
    check("idle_state", 32'(dbg_state_o), 32'h0);
    check("bus_err", 32'(bus_err), 32'(model_err));
    check("ram_addr_hold", ram_addr, model_last_addr);
  endtask

  task automatic run_round(input bit do_i, input bit do_d, input bit d_wr, input bit d_rd_too,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                           input int il, input int dl);
    bit d_first;
    d_first = do_d && (!do_i || !model_last_d);
    if (d_first) begin
      plan(1'b1, d_wr, da, ds, dl, 1'b1);
      if (do_i) plan(1'b0, 1'b0, ia, 32'h0, il, 1'b1);
    end else begin
      if (do_i) plan(1'b0, 1'b0, ia, 32'h0, il, 1'b1);
      if (do_d) plan(1'b1, d_wr, da, ds, dl, 1'b1);
    end
    @(posedge CLK);
    #1;
    iREN   = do_i;
    iaddr  = ia;
    dREN   = do_d && (!d_wr || d_rd_too);
    dWEN   = do_d && d_wr;
    daddr  = da;
    dstore = ds;
    if (do_i ^ do_d) begin
      // Single requester: scramble its inputs right after the grant edge.
      @(posedge CLK);
      #1;
      iaddr  = $urandom;
      daddr  = $urandom;
      dstore = $urandom;
    end
    wait_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   n;
    acc_t e;
    bit   ri, rd, rw;
    RST = 1'b1;
    iREN = 1'b0; iaddr = 32'h0;
    dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
    model_last_d = 1'b0; model_err = 1'b0; model_last_addr = 32'h0;
    ram_mem[32'h40] = 32'h2002000A;
    ref_mem[32'h40] = 32'h2002000A;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ram_ren", 32'(ram_ren), 32'h0);
    check("rst_ram_wen", 32'(ram_wen), 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_store", ram_store, 32'h0);
    check("rst_iwait", 32'(iwait), 32'h1);
    check("rst_dwait", 32'(dwait), 32'h1);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_state", 32'(dbg_state_o), 32'h0);
    RST = 1'b0;

    // Lone icache read, ready in 3rd strobe cycle
    run_round(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 2, 0);
    // Contention after reset: data first, then instr; again: data first
    run_round(1, 1, 0, 0, 32'h44, 32'h48, 32'h0, 1, 0);
    run_round(1, 1, 0, 0, 32'h4C, 32'h50, 32'h0, 0, 2);
    // Data write, then read it back
    run_round(0, 1, 1, 0, 32'h0, 32'h100, 32'hDEADBEEF, 0, 1);
    run_round(0, 1, 0, 0, 32'h0, 32'h100, 32'h0, 0, 0);
    // Ready on the timeout cycle: normal completion, no bus_err
    run_round(1, 0, 0, 0, 32'h104, 32'h0, 32'h0, TIMEOUT - 1, 0);
    // Timeout on a data read
    run_round(0, 1, 0, 0, 32'h0, 32'h108, 32'h0, 0, NEVER);

    // Dropped request: iREN released after grant, pending dREN served next
    plan(1'b0, 1'b0, 32'h80, 32'h0, 3, 1'b0);
    @(posedge CLK);
    #1;
    iREN = 1'b1; iaddr = 32'h80;
    @(posedge CLK);
    #1;
    check("drop_granted_state", 32'(dbg_state_o), 32'h1);
    iREN = 1'b0;
    dREN = 1'b1; daddr = 32'h84;
    plan(1'b1, 1'b0, 32'h84, 32'h0, 1, 1'b1);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(dbg_state_o == 2'd1 && ram_ready) && n < 20);
    check("drop_ready_seen", 32'(n < 20), 32'h1);
    check("drop_iwait", 32'(iwait), 32'h1);
    @(negedge CLK);
    check("drop_back_idle", 32'(dbg_state_o), 32'h0);
    @(negedge CLK);
    check("drop_next_grant", 32'(dbg_state_o), 32'h2);
    wait_idle();

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) rd = 1'b1;
      rw = 1'($urandom_range(0, 1));
      run_round(ri, rd, rw, 1'($urandom_range(0, 1)),
                32'h200 | (32'($urandom_range(0, 7)) << 2),
                32'h200 | (32'($urandom_range(0, 7)) << 2),
                $urandom, $urandom_range(0, TIMEOUT + 1), $urandom_range(0, TIMEOUT + 1));
    end

    // Reset in the middle of a data write
    e.lat = NEVER; e.addr = 32'h300; e.wr = 1'b1; e.store = 32'h12345678; e.abort = 1'b1;
    lat_q.push_back(e);
    @(posedge CLK);
    #1;
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h12345678;
    @(posedge CLK);
    #1;
    check("mid_ram_wen", 32'(ram_wen), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_ram_wen", 32'(ram_wen), 32'h0);
    check("mid_rst_ram_ren", 32'(ram_ren), 32'h0);
    check("mid_rst_dwait", 32'(dwait), 32'h1);
    check("mid_rst_iwait", 32'(iwait), 32'h1);
    check("mid_rst_ram_addr", ram_addr, 32'h0);
    check("mid_rst_ram_store", ram_store, 32'h0);
    check("mid_rst_bus_err", 32'(bus_err), 32'h0);
    check("mid_rst_state", 32'(dbg_state_o), 32'h0);
    dWEN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("final_exp_q", 32'(exp_q.size()), 32'h0);
    check("final_lat_q", 32'(lat_q.size()), 32'h0);
    check("final_state", 32'(dbg_state_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-core memory arbiter sitting directly upstream of the instruction cache and data cache. It accepts word requests from the icache (read-only) and dcache (read/write), serializes them onto one RAM port, and returns `iload`/`dload` with `iwait`/`dwait` handshakes. Fairness between the two requesters is alternating, and a per-access watchdog prevents a hung RAM from stalling the core forever.

## Interface
Parameters:
- `TIMEOUT`, 64: max cycles an access may wait for `ram_ready` before abort; legal range 2..255.
- `BAD`, 32'hBAD1BAD1: word returned on an aborted read.

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  asynchronous active-high reset.
- `iREN`  in  1  icache read request, held until `iwait` low.
- `iaddr`  in  32  icache word address.
- `iload`  out  32  instruction word, valid only in the cycle `iwait`=0.
- `iwait`  out  1  0 for exactly one cycle when the icache access completes.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `dload`  out  32  data word, valid only in the cycle `dwait`=0.
- `dwait`  out  1  0 for exactly one cycle when the dcache access completes.
- `ram_ren`  out  1  RAM read strobe.
- `ram_wen`  out  1  RAM write strobe.
- `ram_addr`  out  32  RAM address (latched request address).
- `ram_store`  out  32  RAM write data (latched).
- `ram_load`  in  32  RAM read data, valid with `ram_ready`.
- `ram_ready`  in  1  one-cycle pulse: current RAM access finished.
- `bus_err`  out  1  sticky; set on any watchdog abort, cleared only by reset.

## Operation
- States: IDLE, INSTR, DATA.
- IDLE: evaluate requests. Data pending = `dREN|dWEN`. Only one pending -> grant it. Both pending -> grant the requester opposite `last_grant`; then `last_grant` updates to the winner. On grant, latch address, `dstore`, and direction (write if `dWEN`; `dREN&dWEN` together counts as write).
- INSTR: `ram_ren`=1. DATA: `ram_ren`=~write, `ram_wen`=write. IDLE: both strobes 0.
- On `ram_ready` in INSTR/DATA: if the granted requester still asserts its enable, drive its wait low for that cycle; `iload`/`dload` = `ram_load` combinationally. If it dropped its enable mid-access, discard the result, with wait staying 1. Next state IDLE.
- Watchdog: 8-bit counter cleared on entry to INSTR/DATA, incremented each cycle there. When count = `TIMEOUT-1` without `ram_ready`: abort, load = `BAD`, pulse the requester's wait low, set `bus_err`, next state IDLE.
- Outside their completion cycle, `iload`/`dload` = `ram_load` (don't-care for the consumer). `iwait`/`dwait` are 1 whenever not completing, including when idle.
- `ram_addr`/`ram_store` hold their last latched values while in IDLE.

## Timing
- Reset values: state IDLE, `last_grant`=INSTR (first contested grant goes to data), `ram_ren`=0, `ram_wen`=0, `ram_addr`=0, `ram_store`=0, `iwait`=1, `dwait`=1, `bus_err`=0, counter 0.
- Latency: request seen in IDLE at cycle 0; strobe high from cycle 1; completion in the cycle `ram_ready`=1 (earliest cycle 1). Minimum access is 2 cycles. One IDLE cycle always separates back-to-back accesses.
- Request address/data changes after grant are ignored until the next grant.
- `ram_ready` while IDLE is ignored.
- `ram_ready` in the same cycle as the timeout count: a normal completion wins; `bus_err` is not set.
- `RST` mid-access: immediately IDLE, strobes drop asynchronously, no completion is reported.

## Test plan
- Lone icache read: `iREN`=1, `iaddr`=0x40, `ram_ready` pulses in the 3rd cycle after grant with `ram_load`=0x2002000A -> `ram_ren` high for 3 cycles, `ram_addr`=0x40, `iwait`=0 for one cycle with `iload`=0x2002000A, then IDLE.
- Contention after reset: `iREN` and `dREN` both asserted in the same cycle -> data granted first. After completion, instruction granted next. Re-assert both -> data again (alternation).
- Data write: `dWEN`=1, `daddr`=0x100, `dstore`=0xDEADBEEF, ready after 1 cycle -> `ram_wen`=1, `ram_ren`=0, `ram_store`=0xDEADBEEF, `dwait` low once.
- Timeout: `TIMEOUT`=4, `dREN`=1, `ram_ready` never -> `ram_ren` high for 4 cycles, then `dwait`=0 with `dload`=0xBAD1BAD1, `bus_err`=1 and staying 1.
- Dropped request: `iREN` deasserted after grant, `ram_ready` later -> `iwait` stays 1, state returns to IDLE, and a pending `dREN` is granted the next cycle.
- Reset mid-access: assert `RST` during DATA -> `ram_ren`/`ram_wen` drop at once and all outputs take their reset values.
